alu_issue: RTL and testbench
============================

// Module: alu_issue
// PURPOSE
// - Decode/issue stage that produces the ALU control bundle: op, sub_sra, src1/src2 select, imm, operands.
// - Takes a 32-bit RV64I instruction plus its PC from fetch; reads the regfile through combinational ports.
// - Presents one registered bundle per instruction to execute over a valid/ready handshake; supports flush.
// PARAMETERS
// - XLEN      64  datapath width of pc/imm/operand buses
// - REG_AW    5   register address width
// PORTS
// - clk_in          in   1      clock; all state on rising edge
// - rst_n_in        in   1      reset, synchronous, active-low
// - in_valid_in     in   1      fetch has instruction
// - in_ready_out    out  1      stage accepts instruction this cycle
// - instr_in        in   32     instruction word
// - pc_in           in   XLEN   instruction PC
// - flush_in        in   1      kill held bundle and any input this cycle
// - rs1_addr_out    out  REG_AW regfile read addr 1 = instr_in[19:15] (comb)
// - rs2_addr_out    out  REG_AW regfile read addr 2 = instr_in[24:20] (comb)
// - rs1_data_in     in   XLEN   regfile read data 1, same cycle
// - rs2_data_in     in   XLEN   regfile read data 2, same cycle
// - out_valid_out   out  1      bundle valid
// - out_ready_in    in   1      execute consumes bundle
// - op_out          out  3      0 ADD_SUB,1 XOR,2 OR,3 AND,4 SLL,5 SRL_SRA,6 SLT,7 SLTU
// - sub_sra_out     out  1      subtract / arithmetic shift
// - src1_out        out  2      0 REG,1 PC,2 ZERO
// - src2_out        out  2      0 REG,1 IMM,2 FOUR
// - kind_out        out  3      0 ALU,1 LUI/AUIPC,2 JUMP,3 BRANCH,4 LOAD,5 STORE
// - funct3_out      out  3      raw funct3 (branch cond / mem size)
// - rd_out          out  REG_AW destination (0 for BRANCH/STORE)
// - pc_out, imm_out, rs1_value_out, rs2_value_out  out XLEN  registered payload
// - illegal_out     out  1      instruction not decodable
// BEHAVIOUR
// - Reset: out_valid_out=0, every registered output 0.
// - in_ready_out = !flush_in && (!out_valid_out || out_ready_in). Accept = in_valid_in && in_ready_out.
// - Accept: whole bundle registered, out_valid_out=1 next cycle; latency 1 cycle, throughput 1/cycle.
// - Consume without accept: out_valid_out->0. out_valid_out && !out_ready_in: payload held bit-stable.
// - flush_in: out_valid_out->0 next cycle, input dropped; flush beats accept and consume.
// - Imm sign-extended to XLEN: I, S, B, J formats; U = {sext(instr[31:12]),12'b0}.
// - OP/OP-IMM: op from funct3 (000 ADD,001 SLL,010 SLT,011 SLTU,100 XOR,101 SRL_SRA,110 OR,111 AND);
//   sub_sra = instr[30] for OP ADD/SRL_SRA and OP-IMM SRL_SRA; OP-IMM ADD never subtracts.
// - LUI: ZERO+IMM ADD. AUIPC: PC+IMM ADD. JAL/JALR: PC+FOUR ADD (link value); kind JUMP.
// - BRANCH: REG,REG; BEQ/BNE SUB, BLT/BGE SLT, BLTU/BGEU SLTU. LOAD/STORE: REG+IMM ADD.
// - Illegal (unknown opcode/funct, bad funct7, shamt rule violated): illegal_out=1, op=ADD, srcs ZERO/IMM,
//   imm 0, rd 0; still handshaken like a normal bundle.
// - rs1_value_out/rs2_value_out latch rs1_data_in/rs2_data_in at accept; no hazard check in this stage.
// CONFIGURATION
// - ALU_ISSUE_RV64W_EN defined: OP-32/OP-IMM-32 decoded (ADDW,SUBW,SLLW,SRLW,SRAW + imm forms),
//   extra port word_out (1) = 1 for them, 0 otherwise; reset 0; shamt[5]=1 on *IW is illegal.
// - Not defined: no word_out port; opcodes 0111011/0011011 -> illegal_out=1.
// TESTING
// - ADDI x1,x0,5 (0x00500093) -> op 0, sub 0, src1 REG, src2 IMM, imm 5, rd 1, kind ALU, 1 cycle later.
// - SUB x3,x1,x2 (0x402081B3), rs1=10, rs2=3 -> sub 1, src2 REG, rs1_value 10, rs2_value 3, rd 3.
// - SRAI x5,x6,63 (0x43F35293) -> op 5, sub 1, imm 0x43F; LUI x7,0x80000 (0x800003B7) -> imm 0xFFFFFFFF80000000.
// - Back-to-back 4 instrs, out_ready_in low cycles 2-4 -> in_ready_out 0, payload stable, none lost/duplicated.
// - flush_in with in_valid_in=1 and bundle held -> out_valid_out 0 next cycle, that input not issued.
// - 0xFFFFFFFF -> illegal_out 1, rd 0; reset mid-stream -> all outputs 0 next edge; 0x0000003B per macro.

Source files
------------

// File: rtl/alu_issue.sv
// alu_issue: RV64I decode/issue stage producing the ALU control bundle.
//
// Decodes a 32-bit instruction from fetch, reads the register file through
// combinational address/data ports, and presents one registered bundle per
// instruction to execute over a valid/ready handshake. flush_in kills the
// held bundle and drops any input offered in the same cycle.
//
// Optional feature macro: ALU_ISSUE_RV64W_EN
//   defined     -> OP-32 / OP-IMM-32 decoded, word_out port present.
//   not defined -> those opcodes decode as illegal, no word_out port.
//
// Ports:
//   clk_in, rst_n_in            clock, synchronous active-low reset
//   in_valid_in / in_ready_out  fetch-side handshake
//   instr_in, pc_in             instruction word and its PC
//   flush_in                    kill held bundle and this cycle's input
//   rs1/rs2_addr_out            regfile read addresses (combinational)
//   rs1/rs2_data_in             regfile read data (same cycle)
//   out_valid_out / out_ready_in execute-side handshake
//   op_out, sub_sra_out, src1_out, src2_out, kind_out, funct3_out, rd_out,
//   pc_out, imm_out, rs1_value_out, rs2_value_out, illegal_out
//                               registered control bundle and payload
module alu_issue #(
  parameter int XLEN   = 64,
  parameter int REG_AW = 5
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic              in_valid_in,
  output logic              in_ready_out,
  input  logic [31:0]       instr_in,
  input  logic [XLEN-1:0]   pc_in,
  input  logic              flush_in,
  output logic [REG_AW-1:0] rs1_addr_out,
  output logic [REG_AW-1:0] rs2_addr_out,
  input  logic [XLEN-1:0]   rs1_data_in,
  input  logic [XLEN-1:0]   rs2_data_in,
  output logic              out_valid_out,
  input  logic              out_ready_in,
  output logic [2:0]        op_out,
  output logic              sub_sra_out,
  output logic [1:0]        src1_out,
  output logic [1:0]        src2_out,
  output logic [2:0]        kind_out,
  output logic [2:0]        funct3_out,
  output logic [REG_AW-1:0] rd_out,
  output logic [XLEN-1:0]   pc_out,
  output logic [XLEN-1:0]   imm_out,
  output logic [XLEN-1:0]   rs1_value_out,
  output logic [XLEN-1:0]   rs2_value_out,
`ifdef ALU_ISSUE_RV64W_EN
  output logic              word_out,
`endif
  output logic              illegal_out
);

  localparam logic [2:0] OP_ADD = 3'd0, OP_XOR = 3'd1, OP_OR  = 3'd2, OP_AND  = 3'd3;
  localparam logic [2:0] OP_SLL = 3'd4, OP_SRL = 3'd5, OP_SLT = 3'd6, OP_SLTU = 3'd7;
  localparam logic [1:0] SRC1_REG = 2'd0, SRC1_PC = 2'd1, SRC1_ZERO = 2'd2;
  localparam logic [1:0] SRC2_REG = 2'd0, SRC2_IMM = 2'd1, SRC2_FOUR = 2'd2;
  localparam logic [2:0] KIND_ALU = 3'd0, KIND_UPPER = 3'd1, KIND_JUMP = 3'd2;
  localparam logic [2:0] KIND_BRANCH = 3'd3, KIND_LOAD = 3'd4, KIND_STORE = 3'd5;

  function automatic logic [2:0] alu_op(input logic [2:0] f3);
    case (f3)
      3'b000:  alu_op = OP_ADD;
      3'b001:  alu_op = OP_SLL;
      3'b010:  alu_op = OP_SLT;
      3'b011:  alu_op = OP_SLTU;
      3'b100:  alu_op = OP_XOR;
      3'b101:  alu_op = OP_SRL;
      3'b110:  alu_op = OP_OR;
      default: alu_op = OP_AND;
    endcase
  endfunction

  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  logic signed [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign opcode = instr_in[6:0];
  assign funct3 = instr_in[14:12];
  assign funct7 = instr_in[31:25];

  assign imm_i = {{(XLEN-12){instr_in[31]}}, instr_in[31:20]};
  assign imm_s = {{(XLEN-12){instr_in[31]}}, instr_in[31:25], instr_in[11:7]};
  assign imm_b = {{(XLEN-12){instr_in[31]}}, instr_in[7], instr_in[30:25], instr_in[11:8], 1'b0};
  assign imm_u = {{(XLEN-32){instr_in[31]}}, instr_in[31:12], 12'b0};
  assign imm_j = {{(XLEN-20){instr_in[31]}}, instr_in[19:12], instr_in[20], instr_in[30:21], 1'b0};

  assign rs1_addr_out = REG_AW'(instr_in[19:15]);
  assign rs2_addr_out = REG_AW'(instr_in[24:20]);

  logic [2:0]        dec_op, dec_kind;
  logic              dec_sub, dec_illegal;
  logic [1:0]        dec_src1, dec_src2;
  logic [REG_AW-1:0] dec_rd;
  logic signed [XLEN-1:0] dec_imm;
`ifdef ALU_ISSUE_RV64W_EN
  logic              dec_word;
`endif

  always_comb begin
    dec_op      = OP_ADD;
    dec_sub     = 1'b0;
    dec_src1    = SRC1_REG;
    dec_src2    = SRC2_IMM;
    dec_kind    = KIND_ALU;
    dec_imm     = imm_i;
    dec_rd      = REG_AW'(instr_in[11:7]);
    dec_illegal = 1'b0;
`ifdef ALU_ISSUE_RV64W_EN
    dec_word    = 1'b0;
`endif
    case (opcode)
      7'b0010011: begin // OP-IMM; RV64 shamt is 6 bits, so only instr[31:26] is funct
        dec_op = alu_op(funct3);
        if (funct3 == 3'b001) begin
          dec_illegal = (instr_in[31:26] != 6'b000000);
        end else if (funct3 == 3'b101) begin
          dec_illegal = (instr_in[31:26] != 6'b000000) && (instr_in[31:26] != 6'b010000);
          dec_sub     = instr_in[30];
        end
      end
      7'b0110011: begin // OP
        dec_op   = alu_op(funct3);
        dec_src2 = SRC2_REG;
        dec_imm  = '0;
        if (funct7 == 7'b0100000) begin
          dec_illegal = !(funct3 == 3'b000 || funct3 == 3'b101);
          dec_sub     = 1'b1;
        end else begin
          dec_illegal = (funct7 != 7'b0000000);
        end
      end
      7'b0110111: begin // LUI
        dec_src1 = SRC1_ZERO;
        dec_kind = KIND_UPPER;
        dec_imm  = imm_u;
      end
      7'b0010111: begin // AUIPC
        dec_src1 = SRC1_PC;
        dec_kind = KIND_UPPER;
        dec_imm  = imm_u;
      end
      7'b1101111: begin // JAL: ALU computes the link value PC+4
        dec_src1 = SRC1_PC;
        dec_src2 = SRC2_FOUR;
        dec_kind = KIND_JUMP;
        dec_imm  = imm_j;
      end
      7'b1100111: begin // JALR
        dec_src1    = SRC1_PC;
        dec_src2    = SRC2_FOUR;
        dec_kind    = KIND_JUMP;
        dec_illegal = (funct3 != 3'b000);
      end
      7'b1100011: begin // BRANCH
        dec_src2 = SRC2_REG;
        dec_kind = KIND_BRANCH;
        dec_imm  = imm_b;
        dec_rd   = '0;
        case (funct3[2:1])
          2'b00:   dec_sub = 1'b1;
          2'b10:   dec_op  = OP_SLT;
          2'b11:   dec_op  = OP_SLTU;
          default: dec_illegal = 1'b1;
        endcase
      end
      7'b0000011: begin // LOAD (LB..LWU, no 111)
        dec_kind    = KIND_LOAD;
        dec_illegal = (funct3 == 3'b111);
      end
      7'b0100011: begin // STORE (SB..SD)
        dec_kind    = KIND_STORE;
        dec_imm     = imm_s;
        dec_rd      = '0;
        dec_illegal = funct3[2];
      end
`ifdef ALU_ISSUE_RV64W_EN
      7'b0111011: begin // OP-32
        dec_op   = alu_op(funct3);
        dec_src2 = SRC2_REG;
        dec_imm  = '0;
        dec_word = 1'b1;
        dec_sub  = instr_in[30];
        if (funct7 == 7'b0000000)
          dec_illegal = !(funct3 == 3'b000 || funct3 == 3'b001 || funct3 == 3'b101);
        else if (funct7 == 7'b0100000)
          dec_illegal = !(funct3 == 3'b000 || funct3 == 3'b101);
        else
          dec_illegal = 1'b1;
      end
      7'b0011011: begin // OP-IMM-32; shamt is 5 bits so instr[25] must be 0
        dec_op   = alu_op(funct3);
        dec_word = 1'b1;
        case (funct3)
          3'b000:  dec_illegal = 1'b0;
          3'b001:  dec_illegal = (funct7 != 7'b0000000);
          3'b101: begin
            dec_illegal = (funct7 != 7'b0000000) && (funct7 != 7'b0100000);
            dec_sub     = instr_in[30];
          end
          default: dec_illegal = 1'b1;
        endcase
      end
`endif
      default: dec_illegal = 1'b1;
    endcase
    // Illegal instructions issue as a harmless ZERO+0 ADD with no destination.
    if (dec_illegal) begin
      dec_op   = OP_ADD;
      dec_sub  = 1'b0;
      dec_src1 = SRC1_ZERO;
      dec_src2 = SRC2_IMM;
      dec_kind = KIND_ALU;
      dec_imm  = '0;
      dec_rd   = '0;
`ifdef ALU_ISSUE_RV64W_EN
      dec_word = 1'b0;
`endif
    end
  end

  logic accept;
  assign in_ready_out = !flush_in && (!out_valid_out || out_ready_in);
  assign accept       = in_valid_in && in_ready_out;

  // ---- stage p1: registered issue bundle ----
  logic              vld_p1, sub_p1, illegal_p1;
  logic [2:0]        op_p1, kind_p1, funct3_p1;
  logic [1:0]        src1_p1, src2_p1;
  logic [REG_AW-1:0] rd_p1;
  logic [XLEN-1:0]   pc_p1, rs1_p1, rs2_p1;
  logic signed [XLEN-1:0] imm_p1;
`ifdef ALU_ISSUE_RV64W_EN
  logic              word_p1;
`endif

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      vld_p1     <= 1'b0;
      sub_p1     <= 1'b0;
      illegal_p1 <= 1'b0;
      op_p1      <= '0;
      kind_p1    <= '0;
      funct3_p1  <= '0;
      src1_p1    <= '0;
      src2_p1    <= '0;
      rd_p1      <= '0;
      pc_p1      <= '0;
      rs1_p1     <= '0;
      rs2_p1     <= '0;
      imm_p1     <= '0;
`ifdef ALU_ISSUE_RV64W_EN
      word_p1    <= 1'b0;
`endif
    end else if (flush_in) begin
      vld_p1 <= 1'b0;
    end else if (accept) begin
      vld_p1     <= 1'b1;
      sub_p1     <= dec_sub;
      illegal_p1 <= dec_illegal;
      op_p1      <= dec_op;
      kind_p1    <= dec_kind;
      funct3_p1  <= funct3;
      src1_p1    <= dec_src1;
      src2_p1    <= dec_src2;
      rd_p1      <= dec_rd;
      pc_p1      <= pc_in;
      rs1_p1     <= rs1_data_in;
      rs2_p1     <= rs2_data_in;
      imm_p1     <= dec_imm;
`ifdef ALU_ISSUE_RV64W_EN
      word_p1    <= dec_word;
`endif
    end else if (out_ready_in) begin
      vld_p1 <= 1'b0;
    end
  end

  assign out_valid_out = vld_p1;
  assign op_out        = op_p1;
  assign sub_sra_out   = sub_p1;
  assign src1_out      = src1_p1;
  assign src2_out      = src2_p1;
  assign kind_out      = kind_p1;
  assign funct3_out    = funct3_p1;
  assign rd_out        = rd_p1;
  assign pc_out        = pc_p1;
  assign imm_out       = imm_p1;
  assign rs1_value_out = rs1_p1;
  assign rs2_value_out = rs2_p1;
  assign illegal_out   = illegal_p1;
`ifdef ALU_ISSUE_RV64W_EN
  assign word_out      = word_p1;
`endif

endmodule

// File: tb/tb_alu_issue.sv
// Directed testbench for alu_issue: reset, decode of representative
// instructions, back-to-back issue with execute stalls, flush, illegal
// encodings, mid-stream reset and the optional RV64W decode.
module tb_alu_issue;

  logic        clk, rst_n, in_valid, in_ready, flush, out_valid, out_ready;
  logic [31:0] instr;
  logic [63:0] pc, rs1_data, rs2_data, pc_o, imm_o, rs1_val, rs2_val;
  logic [4:0]  rs1_addr, rs2_addr, rd;
  logic [2:0]  op, kind, funct3;
  logic [1:0]  src1, src2;
  logic        sub_sra, illegal;
`ifdef ALU_ISSUE_RV64W_EN
  logic        word;
`endif

  int total  = 0;
  int passed = 0;

  alu_issue #(.XLEN(64), .REG_AW(5)) dut (
    .clk_in(clk), .rst_n_in(rst_n),
    .in_valid_in(in_valid), .in_ready_out(in_ready),
    .instr_in(instr), .pc_in(pc), .flush_in(flush),
    .rs1_addr_out(rs1_addr), .rs2_addr_out(rs2_addr),
    .rs1_data_in(rs1_data), .rs2_data_in(rs2_data),
    .out_valid_out(out_valid), .out_ready_in(out_ready),
    .op_out(op), .sub_sra_out(sub_sra), .src1_out(src1), .src2_out(src2),
    .kind_out(kind), .funct3_out(funct3), .rd_out(rd),
    .pc_out(pc_o), .imm_out(imm_o), .rs1_value_out(rs1_val), .rs2_value_out(rs2_val),
`ifdef ALU_ISSUE_RV64W_EN
    .word_out(word),
`endif
    .illegal_out(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] addi(input int rdn, input int immv);
    logic [11:0] i12;
    logic [4:0]  r5;
    i12 = 12'(immv);
    r5  = 5'(rdn);
    return {i12, 5'd0, 3'b000, r5, 7'b0010011};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    instr = 32'h0; pc = 64'h0; rs1_data = 64'h0; rs2_data = 64'h0;
    step(); step();
    total++; if (out_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", out_valid); else passed++;
    total++; if ({op, sub_sra, src1, src2, kind, funct3, rd, illegal} !== 20'h0)
      $display("FAIL reset_ctrl got %h want 0", {op, sub_sra, src1, src2, kind, funct3, rd, illegal}); else passed++;
    total++; if ((pc_o | imm_o | rs1_val | rs2_val) !== 64'h0)
      $display("FAIL reset_payload got %h want 0", pc_o | imm_o | rs1_val | rs2_val); else passed++;
    total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready); else passed++;
`ifdef ALU_ISSUE_RV64W_EN
    total++; if (word !== 1'b0) $display("FAIL reset_word got %b want 0", word); else passed++;
`endif
    rst_n = 1'b1;
  endtask

  task automatic test_addi();
    out_ready = 1'b1; in_valid = 1'b1; instr = 32'h00500093; pc = 64'h1000;
    #1;
    total++; if ({rs1_addr, rs2_addr} !== {5'd0, 5'd5})
      $display("FAIL addi_rs_addr got %h want %h", {rs1_addr, rs2_addr}, {5'd0, 5'd5}); else passed++;
    step();
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b1) $display("FAIL addi_valid got %b want 1", out_valid); else passed++;
    total++; if ({op, sub_sra, src1, src2, kind, rd, illegal} !== {3'd0, 1'b0, 2'd0, 2'd1, 3'd0, 5'd1, 1'b0})
      $display("FAIL addi_ctrl got %h want %h", {op, sub_sra, src1, src2, kind, rd, illegal},
               {3'd0, 1'b0, 2'd0, 2'd1, 3'd0, 5'd1, 1'b0}); else passed++;
    total++; if (imm_o !== 64'd5) $display("FAIL addi_imm got %h want 5", imm_o); else passed++;
    total++; if (pc_o !== 64'h1000) $display("FAIL addi_pc got %h want 1000", pc_o); else passed++;
    step();
    total++; if (out_valid !== 1'b0) $display("FAIL addi_drain got %b want 0", out_valid); else passed++;
  endtask

  task automatic test_sub();
    in_valid = 1'b1; instr = 32'h402081B3; rs1_data = 64'd10; rs2_data = 64'd3;
    step();
    in_valid = 1'b0; rs1_data = 64'd0; rs2_data = 64'd0;
    total++; if ({op, sub_sra, src1, src2, rd, illegal} !== {3'd0, 1'b1, 2'd0, 2'd0, 5'd3, 1'b0})
      $display("FAIL sub_ctrl got %h want %h", {op, sub_sra, src1, src2, rd, illegal},
               {3'd0, 1'b1, 2'd0, 2'd0, 5'd3, 1'b0}); else passed++;
    total++; if ({rs1_val, rs2_val} !== {64'd10, 64'd3})
      $display("FAIL sub_values got %0d,%0d want 10,3", rs1_val, rs2_val); else passed++;
    step();
  endtask

  task automatic test_srai_lui();
    in_valid = 1'b1; instr = 32'h43F35293;
    step();
    instr = 32'h800003B7;
    total++; if ({op, sub_sra, src2, rd} !== {3'd5, 1'b1, 2'd1, 5'd5})
      $display("FAIL srai_ctrl got %h want %h", {op, sub_sra, src2, rd}, {3'd5, 1'b1, 2'd1, 5'd5}); else passed++;
    total++; if (imm_o !== 64'h43F) $display("FAIL srai_imm got %h want 43f", imm_o); else passed++;
    step();
    in_valid = 1'b0;
    total++; if ({op, src1, src2, kind, rd} !== {3'd0, 2'd2, 2'd1, 3'd1, 5'd7})
      $display("FAIL lui_ctrl got %h want %h", {op, src1, src2, kind, rd}, {3'd0, 2'd2, 2'd1, 3'd1, 5'd7}); else passed++;
    total++; if (imm_o !== 64'hFFFFFFFF80000000)
      $display("FAIL lui_imm got %h want ffffffff80000000", imm_o); else passed++;
    step();
  endtask

  task automatic test_branch_jal();
    in_valid = 1'b1; instr = 32'h0020C463; // BLT x1,x2,+8
    step();
    instr = 32'h010000EF;                  // JAL x1,+16
    total++; if ({op, sub_sra, src1, src2, kind, funct3, rd} !== {3'd6, 1'b0, 2'd0, 2'd0, 3'd3, 3'd4, 5'd0})
      $display("FAIL blt_ctrl got %h want %h", {op, sub_sra, src1, src2, kind, funct3, rd},
               {3'd6, 1'b0, 2'd0, 2'd0, 3'd3, 3'd4, 5'd0}); else passed++;
    total++; if (imm_o !== 64'd8) $display("FAIL blt_imm got %h want 8", imm_o); else passed++;
    step();
    in_valid = 1'b0;
    total++; if ({op, src1, src2, kind, rd} !== {3'd0, 2'd1, 2'd2, 3'd2, 5'd1})
      $display("FAIL jal_ctrl got %h want %h", {op, src1, src2, kind, rd}, {3'd0, 2'd1, 2'd2, 3'd2, 5'd1}); else passed++;
    total++; if (imm_o !== 64'd16) $display("FAIL jal_imm got %h want 10", imm_o); else passed++;
    step();
  endtask

  task automatic test_back_to_back();
    logic [31:0] prog [4];
    int   drv    [9] = '{0, 1, 2, 2, 2, 2, 3, -1, -1};
    logic rdy    [9] = '{1, 1, 0, 0, 0, 1, 1, 1, 1};
    logic exp_ir [9] = '{1, 1, 0, 0, 0, 1, 1, 1, 1};
    logic exp_ov [9] = '{0, 1, 1, 1, 1, 1, 1, 1, 0};
    int   n_cons = 0;
    for (int k = 0; k < 4; k++) prog[k] = addi(k + 1, (k + 1) * 16);
    for (int c = 0; c < 9; c++) begin
      out_ready = rdy[c];
      if (drv[c] >= 0) begin
        in_valid = 1'b1;
        instr    = prog[drv[c]];
      end else begin
        in_valid = 1'b0;
      end
      #1;
      total++; if (in_ready !== exp_ir[c])
        $display("FAIL b2b_in_ready cycle %0d got %b want %b", c, in_ready, exp_ir[c]); else passed++;
      total++; if (out_valid !== exp_ov[c])
        $display("FAIL b2b_out_valid cycle %0d got %b want %b", c, out_valid, exp_ov[c]); else passed++;
      if (c >= 2 && c <= 4) begin
        total++; if ({rd, imm_o} !== {5'd2, 64'd32})
          $display("FAIL b2b_stall_stable cycle %0d got rd %0d imm %0d want rd 2 imm 32", c, rd, imm_o); else passed++;
      end
      if (exp_ov[c] && rdy[c]) begin
        total++; if ({rd, imm_o} !== {5'(n_cons + 1), 64'((n_cons + 1) * 16)})
          $display("FAIL b2b_order cycle %0d got rd %0d imm %0d want rd %0d imm %0d",
                   c, rd, imm_o, n_cons + 1, (n_cons + 1) * 16); else passed++;
        n_cons++;
      end
      step();
    end
    in_valid = 1'b0;
  endtask

  task automatic test_flush();
    out_ready = 1'b0; in_valid = 1'b1; instr = addi(9, 9);
    step();
    flush = 1'b1; instr = addi(10, 10);
    #1;
    total++; if (in_ready !== 1'b0) $display("FAIL flush_in_ready got %b want 0", in_ready); else passed++;
    total++; if ({out_valid, rd} !== {1'b1, 5'd9})
      $display("FAIL flush_held got %h want %h", {out_valid, rd}, {1'b1, 5'd9}); else passed++;
    step();
    flush = 1'b0; in_valid = 1'b0;
    total++; if (out_valid !== 1'b0) $display("FAIL flush_kill got %b want 0", out_valid); else passed++;
    out_ready = 1'b1;
    step();
    total++; if (out_valid !== 1'b0) $display("FAIL flush_drop got %b want 0", out_valid); else passed++;
  endtask

  task automatic test_illegal();
    out_ready = 1'b1; in_valid = 1'b1; instr = 32'hFFFFFFFF; rs1_data = 64'd123;
    step();
    instr = 32'h022080B3; // MUL: funct7 0000001 not in RV64I
    rs1_data = 64'd0;
    total++; if ({out_valid, illegal, rd} !== {1'b1, 1'b1, 5'd0})
      $display("FAIL ill_flags got %h want %h", {out_valid, illegal, rd}, {1'b1, 1'b1, 5'd0}); else passed++;
    total++; if ({op, sub_sra, src1, src2, kind} !== {3'd0, 1'b0, 2'd2, 2'd1, 3'd0})
      $display("FAIL ill_ctrl got %h want %h", {op, sub_sra, src1, src2, kind}, {3'd0, 1'b0, 2'd2, 2'd1, 3'd0}); else passed++;
    total++; if ({imm_o, rs1_val} !== {64'd0, 64'd123})
      $display("FAIL ill_payload got imm %h rs1 %0d want 0,123", imm_o, rs1_val); else passed++;
    step();
    in_valid = 1'b0;
    total++; if ({out_valid, illegal, rd} !== {1'b1, 1'b1, 5'd0})
      $display("FAIL ill_funct7 got %h want %h", {out_valid, illegal, rd}, {1'b1, 1'b1, 5'd0}); else passed++;
    step();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0; in_valid = 1'b1; instr = addi(5, 7); pc = 64'h2000;
    step();
    rst_n = 1'b0; instr = addi(6, 8);
    step();
    total++; if ({out_valid, rd, op, illegal} !== 10'h0)
      $display("FAIL rstmid_ctrl got %h want 0", {out_valid, rd, op, illegal}); else passed++;
    total++; if ((imm_o | pc_o) !== 64'h0)
      $display("FAIL rstmid_payload got %h want 0", imm_o | pc_o); else passed++;
    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    step();
    total++; if (out_valid !== 1'b0) $display("FAIL rstmid_after got %b want 0", out_valid); else passed++;
  endtask

  task automatic test_word();
    in_valid = 1'b1; instr = 32'h0000003B;
    step();
    in_valid = 1'b0;
`ifdef ALU_ISSUE_RV64W_EN
    total++; if ({out_valid, illegal, word, src2} !== {1'b1, 1'b0, 1'b1, 2'd0})
      $display("FAIL addw_decode got %h want %h", {out_valid, illegal, word, src2}, {1'b1, 1'b0, 1'b1, 2'd0}); else passed++;
`else
    total++; if ({out_valid, illegal, rd} !== {1'b1, 1'b1, 5'd0})
      $display("FAIL addw_illegal got %h want %h", {out_valid, illegal, rd}, {1'b1, 1'b1, 5'd0}); else passed++;
`endif
    step();
  endtask

  initial begin
    test_reset();
    test_addi();
    test_sub();
    test_srai_lui();
    test_branch_jal();
    test_back_to_back();
    test_flush();
    test_illegal();
    test_reset_mid();
    test_word();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
